// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline (freeze > redirect > load-use).
// Define HAZARD_PERF_CNT_EN to build the saturating stall/redirect performance counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IMem_stall_i,
    input  logic        DMem_stall_i,
    input  logic        Redirect_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RDaddr_i,
    input  logic [4:0]  IFID_RS1addr_i,
    input  logic [4:0]  IFID_RS2addr_i,
    output logic        PC_stall_o,
    output logic        PC_redirect_o,
    output logic        IFID_Stall_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Stall_o,
    output logic        IDEX_Flush_o,
    output logic        EXMEM_Stall_o,
    output logic        MEMWB_Stall_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    // state   | meaning
    // RUN     | normal flow, load-use bubbles allowed
    // MEMWAIT | recovering from a memory freeze, behaves like RUN
    // FLUSH   | fetch flush window, cnt_q cycles left
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_DEPTH - 1);

    state_e     state_q, state_d;
    logic       pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d;

    logic mem_stall, load_use, eff_redir;
    logic pc_stall, pc_redirect, ifid_stall, ifid_flush;
    logic idex_stall, idex_flush, exmem_stall, memwb_stall;

    assign mem_stall = IMem_stall_i | DMem_stall_i;
    assign load_use  = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                       ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));
    assign eff_redir = Redirect_i | pend_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_stall = 1'b0;

        if (mem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_stall = 1'b1;
            if (Redirect_i) pend_d = 1'b1;
            state_d = (state_q == ST_FLUSH) ? ST_FLUSH : ST_MEMWAIT;
        end else if (eff_redir) begin
            // A redirect parked during a freeze inside the flush window also restarts the window.
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pend_d      = 1'b0;
            if (FLUSH_DEPTH > 1) begin
                cnt_d   = CNT_RELOAD;
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_FLUSH) begin
            ifid_flush = 1'b1;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = ST_RUN;
        end else begin
            state_d = ST_RUN;
            if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Held low during reset so the pipeline registers' own reset is never masked.
    assign PC_stall_o    = rst_n & pc_stall;
    assign PC_redirect_o = rst_n & pc_redirect;
    assign IFID_Stall_o  = rst_n & ifid_stall;
    assign IFID_Flush_o  = rst_n & ifid_flush;
    assign IDEX_Stall_o  = rst_n & idex_stall;
    assign IDEX_Flush_o  = rst_n & idex_flush;
    assign EXMEM_Stall_o = rst_n & exmem_stall;
    assign MEMWB_Stall_o = rst_n & memwb_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PC_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (PC_redirect_o && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = rst_n ? stall_cnt_q : 32'd0;
    assign flush_cnt_o = rst_n ? flush_cnt_q : 32'd0;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FLUSH_DEPTH=3): directed scenarios then randomized traffic.
module tb_hazard_ctrl;
    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       IMem_stall_i = 1'b0, DMem_stall_i = 1'b0, Redirect_i = 1'b0, IDEX_MemRead_i = 1'b0;
    logic [4:0] IDEX_RDaddr_i = 5'd0, IFID_RS1addr_i = 5'd0, IFID_RS2addr_i = 5'd0;
    logic       PC_stall_o, PC_redirect_o, IFID_Stall_o, IFID_Flush_o;
    logic       IDEX_Stall_o, IDEX_Flush_o, EXMEM_Stall_o, MEMWB_Stall_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.FLUSH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .IMem_stall_i(IMem_stall_i), .DMem_stall_i(DMem_stall_i), .Redirect_i(Redirect_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
        .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
        .PC_stall_o(PC_stall_o), .PC_redirect_o(PC_redirect_o),
        .IFID_Stall_o(IFID_Stall_o), .IFID_Flush_o(IFID_Flush_o),
        .IDEX_Stall_o(IDEX_Stall_o), .IDEX_Flush_o(IDEX_Flush_o),
        .EXMEM_Stall_o(EXMEM_Stall_o), .MEMWB_Stall_o(MEMWB_Stall_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_stall, pc_redirect, ifid_stall, ifid_flush;
        logic        idex_stall, idex_flush, exmem_stall, memwb_stall;
        logic [31:0] stall_cnt, flush_cnt;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    // Reference: remaining flush-window cycles, parked redirect, perf totals.
    int          m_flush_left = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_stall_cnt = 32'd0;
    logic [31:0] m_flush_cnt = 32'd0;

    task automatic cyc(input bit r, input bit im, input bit dm, input bit rd, input bit mr,
                       input logic [4:0] rda, input logic [4:0] r1, input logic [4:0] r2);
        resp_t e;
        bit    lu;
        @(posedge clk);
        #1;
        rst_n = r; IMem_stall_i = im; DMem_stall_i = dm; Redirect_i = rd;
        IDEX_MemRead_i = mr; IDEX_RDaddr_i = rda; IFID_RS1addr_i = r1; IFID_RS2addr_i = r2;
        e  = '0;
        lu = mr && (rda != 5'd0) && ((rda == r1) || (rda == r2));
        if (!r) begin
            m_flush_left = 0;
            m_pend       = 1'b0;
            m_stall_cnt  = 32'd0;
            m_flush_cnt  = 32'd0;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            e.stall_cnt = m_stall_cnt;
            e.flush_cnt = m_flush_cnt;
`endif
            if (im || dm) begin
                {e.pc_stall, e.ifid_stall, e.idex_stall, e.exmem_stall, e.memwb_stall} = 5'b11111;
                if (rd) m_pend = 1'b1;
            end else if (rd || m_pend) begin
                {e.pc_redirect, e.ifid_flush, e.idex_flush} = 3'b111;
                m_pend       = 1'b0;
                m_flush_left = DEPTH - 1;
            end else if (m_flush_left > 0) begin
                e.ifid_flush = 1'b1;
                m_flush_left--;
            end else if (lu) begin
                {e.pc_stall, e.ifid_stall, e.idex_flush} = 3'b111;
            end
            if (e.pc_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (e.pc_redirect && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    resp_t mon_e, mon_a;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {PC_stall_o, PC_redirect_o, IFID_Stall_o, IFID_Flush_o,
                         IDEX_Stall_o, IDEX_Flush_o, EXMEM_Stall_o, MEMWB_Stall_o,
                         stall_cnt_o, flush_cnt_o};
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL resp t=%0t actual=%h required=%h", $time, mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(2);
        // load-use hit on rs2, then the same with rd=x0
        cyc(1, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5);
        cyc(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        idle(2);
        // single redirect pulse, three-cycle fetch flush
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        idle(4);
        // redirect parked during a data-memory freeze, replayed afterwards
        cyc(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(5);
        // priorities: redirect over load-use, freeze over load-use
        cyc(1, 0, 0, 1, 1, 5'd7, 5'd7, 5'd0);
        idle(3);
        cyc(1, 1, 0, 0, 1, 5'd7, 5'd7, 5'd0);
        idle(1);
        // redirect target that is a load-use consumer: bubble after the window
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd1);
        idle(1);
        // reset while frozen with a parked redirect: no replay afterwards
        cyc(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(4);
        // reset mid flush window
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(3);
        // perf scenario: 3-cycle freeze, 1 bubble, 2 redirects
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        idle(3);
        cyc(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
        end
        idle(2);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
